mips32_mem_wb: RTL

- MEM and WB stages for the mips32 pipeline; consumes the EX/MEM pipeline register set that the EX stage drives.
- Owns the data memory and performs loads and stores.
- Produces the register-file write strobe and the processor HALTED flag that the IF, ID and EX stages use for gating.
- Two registered stages on one clock: MEM, then WB.

---
 rtl/mips32_pkg.sv | 41 ++++
 rtl/mips32_dmem.sv | 37 +++
 rtl/mips32_mem_wb.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared opcode, instruction-type and field constants for the mips32 pipeline
package mips32_pkg;

  // Opcodes, IR[31:26]
  localparam logic [5:0] ADD   = 6'b000000;
  localparam logic [5:0] SUB   = 6'b000001;
  localparam logic [5:0] AND   = 6'b000010;
  localparam logic [5:0] OR    = 6'b000011;
  localparam logic [5:0] SLT   = 6'b000100;
  localparam logic [5:0] MUL   = 6'b000101;
  localparam logic [5:0] LW    = 6'b001000;
  localparam logic [5:0] SW    = 6'b001001;
  localparam logic [5:0] ADDI  = 6'b001010;
  localparam logic [5:0] SUBI  = 6'b001011;
  localparam logic [5:0] SLTI  = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101;
  localparam logic [5:0] BEQZ  = 6'b001110;
  localparam logic [5:0] HLT   = 6'b111111;

  // Instruction classes carried down the pipeline
  localparam logic [2:0] RR_ALU = 3'd0;
  localparam logic [2:0] RM_ALU = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] STORE  = 3'd3;
  localparam logic [2:0] BRANCH = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  // Register field positions inside IR
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } halt_state_t;

endpackage

// File: rtl/mips32_dmem.sv
// rtl/mips32_dmem.sv - data memory: one write port, one synchronous read port, combinational debug read
module mips32_dmem #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_rdata
);

  logic [DW-1:0] r_mem [0:(2**AW)-1];
  logic [DW-1:0] r_rdata;

  // Array write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Registered read; holds its last value when not enabled
  always_ff @(posedge clk) begin
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata     = r_rdata;
  assign dbg_rdata = r_mem[dbg_addr];

endmodule

// File: rtl/mips32_mem_wb.sv
// rtl/mips32_mem_wb.sv - MEM and WB stages with data memory and sticky halt FSM
module mips32_mem_wb
  import mips32_pkg::*;
#(
  parameter int DMEM_AW = 10,
  parameter int DW      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic [2:0]         ex_type,
  input  logic [31:0]        ex_ir,
  input  logic [DW-1:0]      ex_aluout,
  input  logic [DW-1:0]      ex_b,
  input  logic               taken_branch,
  output logic               rf_we,
  output logic [4:0]         rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic               halted,
  input  logic [DMEM_AW-1:0] dbg_addr,
  output logic [DW-1:0]      dbg_rdata
);

  halt_state_t r_state;
  halt_state_t w_state_next;

  logic          w_halted;
  logic          w_mem_fire;
  logic          w_mem_store;
  logic          w_mem_load;
  logic [DW-1:0] w_lmd;

  logic          r_valid;
  logic [2:0]    r_type;
  logic [31:0]   r_ir;
  logic [DW-1:0] r_aluout;

  logic          w_wb_fire;
  logic          w_wb_we;
  logic          w_wb_halt;
  logic [4:0]    w_wb_waddr;
  logic [DW-1:0] w_wb_wdata;
  logic          w_unused_ir;

  assign w_halted = (r_state == ST_HALTED);
  assign halted   = w_halted;

  // Squash wins over valid; a halted core or a reset edge never touches memory
  assign w_mem_fire  = ex_valid & ~taken_branch & ~w_halted & ~reset;
  assign w_mem_store = w_mem_fire & (ex_type == STORE);
  assign w_mem_load  = w_mem_fire & (ex_type == LOAD);

  mips32_dmem #(
    .AW (DMEM_AW),
    .DW (DW)
  ) u_dmem (
    .clk       (clk),
    .we        (w_mem_store),
    .waddr     (ex_aluout[DMEM_AW-1:0]),
    .wdata     (ex_b),
    .re        (w_mem_load),
    .raddr     (ex_aluout[DMEM_AW-1:0]),
    .rdata     (w_lmd),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  // MEM/WB pipeline register; frozen once halted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_type   <= BRANCH;
      r_ir     <= '0;
      r_aluout <= '0;
    end else if (!w_halted) begin
      r_valid <= w_mem_fire;
      if (w_mem_fire) begin
        r_type   <= ex_type;
        r_ir     <= ex_ir;
        r_aluout <= ex_aluout;
      end
    end
  end

  // Only the rt/rd fields matter at writeback
  assign w_unused_ir = ^{r_ir[31:21], r_ir[10:0]};

  assign w_wb_fire = r_valid & ~w_halted;

  // Writeback decode; unknown classes behave as HALT
  always_comb begin
    w_wb_we    = 1'b0;
    w_wb_halt  = 1'b0;
    w_wb_waddr = '0;
    w_wb_wdata = '0;
    case (r_type)
      RR_ALU: begin
        w_wb_waddr = r_ir[RD_MSB:RD_LSB];
        w_wb_wdata = r_aluout;
        w_wb_we    = (w_wb_waddr != 5'd0);
      end
      RM_ALU: begin
        w_wb_waddr = r_ir[RT_MSB:RT_LSB];
        w_wb_wdata = r_aluout;
        w_wb_we    = (w_wb_waddr != 5'd0);
      end
      LOAD: begin
        w_wb_waddr = r_ir[RT_MSB:RT_LSB];
        w_wb_wdata = w_lmd;
        w_wb_we    = (w_wb_waddr != 5'd0);
      end
      STORE, BRANCH: begin
        w_wb_we = 1'b0;
      end
      default: begin
        w_wb_halt = 1'b1;
      end
    endcase
  end

  // Register-file write port: one-cycle strobe, address/data held between writes
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= w_wb_fire & w_wb_we;
      if (w_wb_fire && w_wb_we) begin
        rf_waddr <= w_wb_waddr;
        rf_wdata <= w_wb_wdata;
      end
    end
  end

  // Halt FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Halt FSM next state: HALTED is absorbing until reset
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:    if (w_wb_fire && w_wb_halt) w_state_next = ST_HALTED;
      ST_HALTED: w_state_next = ST_HALTED;
      default:   w_state_next = ST_RUN;
    endcase
  end

endmodule
